// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - owner_e    : which requester drives the memory this cycle
//   - DEF_*      : default address/data widths
//   - STAT_W     : width of the optional statistics counters
//   - cnt_width(): bits needed for a counter that saturates at max_val
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STAT_W         = 16;

  typedef enum logic {
    OWNER_CPU    = 1'b0,
    OWNER_LOADER = 1'b1
  } owner_e;

  // A counter saturating at 0 still needs one (constant) bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core M-stage port, the loader/debug master,
// the arbiter and the single-port data memory.
//   cpu_* : core request and load return / stall
//   ld_*  : loader request, grant and registered read return
//   mem_* : memory pins (we/addr/wdata out, combinational rdata in)
// Modports: slave = arbiter side, master = requesters + memory side.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  ld_req;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_gnt;
  logic                  ld_rvalid;
  logic [DATA_WIDTH-1:0] ld_rdata;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_wait_counter.sv
// Saturating loader starvation counter.
//   clk, reset : clock, async active-high reset (count -> 0)
//   inc        : loader requested and was denied this cycle
//   clr        : loader granted or not requesting (wins over inc)
//   at_max     : count has reached MAX_WAIT; loader must win next
module dmem_arb_wait_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int            W     = cnt_width(MAX_WAIT);
  localparam logic [W-1:0]  MAX_V = W'(MAX_WAIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && (cnt != MAX_V)) cnt <= cnt + 1'b1;
  end

  // With MAX_WAIT=0 this is constantly true: the loader always preempts.
  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the
// core M-stage port (default priority) and a loader/debug master. A
// loader denied MAX_WAIT consecutive cycles is forced a slot and the
// core is stalled for that cycle.
//   clk, reset : clock, async active-high reset
//   bus        : dmem_arbiter_if.slave (cpu_*, ld_*, mem_* signals)
//   stall_count, grant_count : only with DMEM_ARB_STATS_EN defined;
//                saturating counts of stall cycles and loader grants
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stall_count,
  output logic [STAT_W-1:0]   grant_count
`endif
);

  owner_e                owner;
  logic                  wait_at_max;
  logic                  gnt;
  logic                  stall;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  dmem_arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (bus.ld_req && !gnt),
    .clr    (gnt || !bus.ld_req),
    .at_max (wait_at_max)
  );

  always_comb begin
    owner = OWNER_CPU;
    if (bus.ld_req && (!bus.cpu_req || wait_at_max)) owner = OWNER_LOADER;
  end

  // Reset masks every side effect so nothing is written while held.
  always_comb begin
    gnt       = 1'b0;
    stall     = 1'b0;
    we_sel    = bus.cpu_req && bus.cpu_we;
    addr_sel  = bus.cpu_addr;
    wdata_sel = bus.cpu_wdata;
    if (owner == OWNER_LOADER) begin
      gnt       = 1'b1;
      stall     = bus.cpu_req;
      we_sel    = bus.ld_we;
      addr_sel  = bus.ld_addr;
      wdata_sel = bus.ld_wdata;
    end
    if (reset) begin
      gnt    = 1'b0;
      stall  = 1'b0;
      we_sel = 1'b0;
    end
  end

  assign bus.ld_gnt    = gnt;
  assign bus.cpu_stall = stall;
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.cpu_rdata = bus.mem_rdata;

  // Loader read return: captured at the edge ending the grant cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt && !bus.ld_we;
      if (gnt && !bus.ld_we) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.ld_rvalid = rvalid_q;
  assign bus.ld_rdata  = rdata_q;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      grant_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (gnt   && (grant_count != '1)) grant_count <= grant_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: DUT a uses MAX_WAIT=4, DUT b MAX_WAIT=0.
// Covers reset, a table of directed vectors, hand sequences for the
// store conflict / MAX_WAIT=0 / mid-read reset, and random traffic
// against a streak-based reference model with its own memory image.
module tb_dmem_arbiter;
  localparam int MW_A = 4;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  always #5 clk = ~clk;

  dmem_arbiter_if ia ();
  dmem_arbiter_if ib ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] sc_a, gc_a, sc_b, gc_b;
`endif

  dmem_arbiter #(.MAX_WAIT(MW_A)) u_a (
    .clk(clk), .reset(reset), .bus(ia)
`ifdef DMEM_ARB_STATS_EN
    , .stall_count(sc_a), .grant_count(gc_a)
`endif
  );

  dmem_arbiter #(.MAX_WAIT(0)) u_b (
    .clk(clk), .reset(reset), .bus(ib)
`ifdef DMEM_ARB_STATS_EN
    , .stall_count(sc_b), .grant_count(gc_b)
`endif
  );

  // Memories (word-indexed by addr[9:2]).
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  assign ia.mem_rdata = mem_a[ia.mem_addr[9:2]];
  assign ib.mem_rdata = mem_b[ib.mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (ia.mem_we) mem_a[ia.mem_addr[9:2]] <= ia.mem_wdata;
      if (ib.mem_we) mem_b[ib.mem_addr[9:2]] <= ib.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        lr, lw;
    logic [31:0] la, ld;
    logic        g, s, w, rv;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                              logic lr, logic lw, logic [31:0] la, logic [31:0] ld,
                              logic g, logic s, logic w, logic rv, logic [31:0] rd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.g = g; v.s = s; v.w = w; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic drive_a(input logic cr, cw, input logic [31:0] ca, cd,
                         input logic lr, lw, input logic [31:0] la, ld);
    ia.cpu_req = cr; ia.cpu_we = cw; ia.cpu_addr = ca; ia.cpu_wdata = cd;
    ia.ld_req  = lr; ia.ld_we  = lw; ia.ld_addr  = la; ia.ld_wdata  = ld;
  endtask

  task automatic drive_b(input logic cr, cw, input logic [31:0] ca, cd,
                         input logic lr, lw, input logic [31:0] la, ld);
    ib.cpu_req = cr; ib.cpu_we = cw; ib.cpu_addr = ca; ib.cpu_wdata = cd;
    ib.ld_req  = lr; ib.ld_we  = lw; ib.ld_addr  = la; ib.ld_wdata  = ld;
  endtask

  // Drive at posedge+1, sample at negedge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  vec_t        tbl [15];
  logic [31:0] model_mem [256];

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1; mem_clr = 1'b1;
    drive_a(0, 0, 0, 0, 1, 1, 32'h10, 32'h5);
    drive_b(1, 1, 32'h20, 32'h6, 1, 1, 32'h10, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt_a", ia.ld_gnt, 0);
    chk("rst_we_a", ia.mem_we, 0);
    chk("rst_rvalid_a", ia.ld_rvalid, 0);
    chk("rst_rdata_a", ia.ld_rdata, 0);
    chk("rst_gnt_b", ib.ld_gnt, 0);
    chk("rst_stall_b", ib.cpu_stall, 0);
    chk("rst_we_b", ib.mem_we, 0);
    reset = 1'b0; mem_clr = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // ---------------- table (DUT a, MAX_WAIT=4) ----------------
    tbl[0] = mk(0,0,0,0,       1,1,32'h40,32'hDEADBEEF, 1,0,1,0,0);
    tbl[1] = mk(0,0,0,0,       1,0,32'h40,0,            1,0,0,0,0);
    tbl[2] = mk(0,0,0,0,       0,0,0,0,                 0,0,0,1,32'hDEADBEEF);
    tbl[3] = mk(0,0,0,0,       0,0,0,0,                 0,0,0,0,32'hDEADBEEF);
    for (int i = 4; i < 8; i++)
      tbl[i] = mk(1,0,32'h40,0, 1,0,32'h44,0,           0,0,0,0,32'hDEADBEEF);
    tbl[8] = mk(1,0,32'h40,0,  1,0,32'h44,0,            1,1,0,0,32'hDEADBEEF);
    tbl[9] = mk(1,0,32'h40,0,  1,0,32'h40,0,            0,0,0,1,0);
    for (int i = 10; i < 13; i++)
      tbl[i] = mk(1,0,32'h40,0, 1,0,32'h40,0,           0,0,0,0,0);
    tbl[13] = mk(1,0,32'h40,0, 1,0,32'h40,0,            1,1,0,0,0);
    tbl[14] = mk(0,0,0,0,      0,0,0,0,                 0,0,0,1,32'hDEADBEEF);

    for (int i = 0; i < 15; i++) begin
      drive_a(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
              tbl[i].lr, tbl[i].lw, tbl[i].la, tbl[i].ld);
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i),    ia.ld_gnt,    tbl[i].g);
      chk($sformatf("tbl%0d_stall", i),  ia.cpu_stall, tbl[i].s);
      chk($sformatf("tbl%0d_we", i),     ia.mem_we,    tbl[i].w);
      chk($sformatf("tbl%0d_rvalid", i), ia.ld_rvalid, tbl[i].rv);
      chk($sformatf("tbl%0d_rdata", i),  ia.ld_rdata,  tbl[i].rd);
      if (i == 4) chk("tbl4_cpu_rdata", ia.cpu_rdata, 32'hDEADBEEF);
      next_cycle();
    end
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- MAX_WAIT=0, both requesting 3 cycles ----------------
    for (int i = 0; i < 3; i++) begin
      drive_b(1, 0, 32'h8, 0, 1, 0, 32'hC, 0);
      @(negedge clk);
      chk($sformatf("mw0_gnt%0d", i), ib.ld_gnt, 1);
      chk($sformatf("mw0_stall%0d", i), ib.cpu_stall, 1);
      next_cycle();
    end
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("stats_stall", sc_b, 3);
    chk("stats_grant", gc_b, 3);
`endif

    // ---------------- store conflict on DUT b ----------------
    drive_b(1, 1, 32'h80, 32'h11, 1, 1, 32'h80, 32'h22);
    @(negedge clk);
    chk("cf_gnt", ib.ld_gnt, 1);
    chk("cf_stall", ib.cpu_stall, 1);
    chk("cf_wdata", ib.mem_wdata, 32'h22);
    next_cycle();
    chk("cf_mem_ld", mem_b[32], 32'h22);
    drive_b(1, 1, 32'h80, 32'h11, 0, 0, 0, 0);
    @(negedge clk);
    chk("cf_retry_stall", ib.cpu_stall, 0);
    chk("cf_retry_we", ib.mem_we, 1);
    next_cycle();
    chk("cf_mem_cpu", mem_b[32], 32'h11);
    // Loader write in cycle N visible to core load in N+1.
    drive_b(0, 0, 0, 0, 1, 1, 32'h84, 32'h33);
    next_cycle();
    drive_b(1, 0, 32'h84, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("vis_cpu_rdata", ib.cpu_rdata, 32'h33);
    next_cycle();
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- reset mid-read on DUT a ----------------
    drive_a(0, 0, 0, 0, 1, 0, 32'h40, 0);
    next_cycle();
    chk("mr_rvalid_pre", ia.ld_rvalid, 1);
    chk("mr_rdata_pre", ia.ld_rdata, 32'hDEADBEEF);
    drive_a(0, 0, 0, 0, 1, 1, 32'h40, 32'h77);
    #1 reset = 1'b1;
    #1;
    chk("mr_gnt", ia.ld_gnt, 0);
    chk("mr_we", ia.mem_we, 0);
    chk("mr_rvalid", ia.ld_rvalid, 0);
    chk("mr_rdata", ia.ld_rdata, 0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // ---------------- random traffic vs reference model (DUT a) ----------------
    begin
      int          streak = 0;
      logic        prev_g = 1'b0;
      logic        exp_rv = 1'b0;
      logic [31:0] exp_rd = '0;
      logic        eg, es, ew;
      logic [31:0] eaddr, edata;
      for (int i = 0; i < 256; i++) model_mem[i] = mem_a[i];
      for (int cyc = 0; cyc < 400; cyc++) begin
        if (!ia.ld_req || prev_g) begin
          ia.ld_req   = ($urandom_range(0, 2) != 0);
          ia.ld_we    = $urandom_range(0, 1) == 1;
          ia.ld_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
          ia.ld_wdata = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          ia.ld_req = 1'b0;
        end
        ia.cpu_req   = ($urandom_range(0, 3) != 0);
        ia.cpu_we    = $urandom_range(0, 1) == 1;
        ia.cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        ia.cpu_wdata = $urandom;
        @(negedge clk);
        eg = ia.ld_req && (!ia.cpu_req || streak >= MW_A);
        es = eg && ia.cpu_req;
        ew = eg ? ia.ld_we : (ia.cpu_req && ia.cpu_we);
        eaddr = eg ? ia.ld_addr : ia.cpu_addr;
        edata = eg ? ia.ld_wdata : ia.cpu_wdata;
        chk("rnd_gnt", ia.ld_gnt, eg);
        chk("rnd_stall", ia.cpu_stall, es);
        chk("rnd_we", ia.mem_we, ew);
        chk("rnd_rvalid", ia.ld_rvalid, exp_rv);
        chk("rnd_rdata", ia.ld_rdata, exp_rd);
        if (ew) begin
          chk("rnd_addr", ia.mem_addr, eaddr);
          chk("rnd_wdata", ia.mem_wdata, edata);
        end
        if (ia.cpu_req && !es && !ia.cpu_we)
          chk("rnd_cpu_rdata", ia.cpu_rdata, model_mem[ia.cpu_addr[9:2]]);
        exp_rv = eg && !ia.ld_we;
        if (exp_rv) exp_rd = model_mem[ia.ld_addr[9:2]];
        if (ew) model_mem[eaddr[9:2]] = edata;
        streak = (ia.ld_req && !eg) ? streak + 1 : 0;
        prev_g = eg;
        next_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipelined core's M-stage load/store port, and a loader/debug master that preloads or inspects data memory.
- The core has default priority. A loader starved for MAX_WAIT cycles is forced a slot, and the core is stalled for that cycle.
- Sits between the arm core and DataMemory in the top level, and drives the memory's we/address/write_data pins.

Parameters:
- ADDR_WIDTH, 32, byte address width of both requesters and the memory.
- DATA_WIDTH, 32, data word width.
- MAX_WAIT, 4, consecutive denied loader cycles before the loader preempts the core. 0 = loader always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  core performs a load or store this cycle.
- cpu_we  in  1  core store.
- cpu_addr  in  ADDR_WIDTH  core address.
- cpu_wdata  in  DATA_WIDTH  core store data.
- cpu_rdata  out  DATA_WIDTH  core load data (combinational from mem_rdata).
- cpu_stall  out  1  core must hold its M stage this cycle.
- ld_req  in  1  loader request; held with we/addr/wdata stable until ld_gnt.
- ld_we  in  1  loader write.
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_wdata  in  DATA_WIDTH  loader write data.
- ld_gnt  out  1  loader access performed this cycle.
- ld_rvalid  out  1  one-cycle pulse: ld_rdata valid.
- ld_rdata  out  DATA_WIDTH  registered loader read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory combinational read data.

Behaviour:
- Clocking: single clk domain. reset is asynchronous, active-high, and clears all state immediately.
- Reset values: wait_cnt=0, ld_rvalid=0, ld_rdata=0.
- While reset is high: ld_gnt=0, mem_we=0, cpu_stall=0.
- Owner select, combinational each cycle:
  - LOADER if ld_req && (!cpu_req || wait_cnt==MAX_WAIT).
  - Otherwise CPU.
- Outputs when LOADER owns:
  - ld_gnt=1.
  - mem_* driven from ld_*.
  - cpu_stall=cpu_req.
- Outputs when CPU owns:
  - ld_gnt=0.
  - mem_we=cpu_req&&cpu_we.
  - mem_addr/mem_wdata from cpu_*.
  - cpu_stall=0.
- cpu_rdata=mem_rdata always. The core ignores it when stalled.
- wait_cnt, width max(1,clog2(MAX_WAIT+1)):
  - +1 on ld_req && !ld_gnt, saturating at MAX_WAIT.
  - Cleared on ld_gnt or !ld_req.
  - So after MAX_WAIT denied cycles, the next cycle grants the loader.
- Loader read return:
  - On ld_gnt && !ld_we: ld_rdata<=mem_rdata and ld_rvalid<=1 next cycle.
  - Otherwise ld_rvalid<=0 and ld_rdata holds its value.
  - Latency: 1 cycle after the grant.
- Write timing: a write commits at the clk edge ending its grant cycle. A stalled core store is re-presented by the core next cycle and commits then.
- Same-address conflicts:
  - A loader write granted in cycle N is visible to a core load in cycle N+1.
  - Ordering is strictly the grant order.
- Back-to-back loader requests while the core is idle: granted every cycle; ld_rvalid may stay high continuously.
- MAX_WAIT=0: the loader always preempts, and wait_cnt stays 0.
- Loader dropping ld_req before its grant: legal. wait_cnt clears and nothing is accessed.
- Reset asserted mid-read: the pending ld_rvalid is lost. The loader must re-request.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds output stall_count (16 bits), incremented every cycle cpu_stall=1, saturating at 16'hFFFF, reset to 0.
  - Adds output grant_count (16 bits), incremented on every ld_gnt, saturating, reset to 0.
- When undefined: neither port nor either counter exists. Arbitration behaviour is identical in both cases.

Decomposition:
- Shared package holds:
  - owner encoding constants (OWNER_CPU=1'b0, OWNER_LOADER=1'b1);
  - default ADDR_WIDTH/DATA_WIDTH;
  - the saturating-counter width helper function.
- One natural sub-module: dmem_arb_wait_counter, the saturating starvation counter with inc/clr/at_max.
- The read-return register and stats counters stay inline.

Test Plan:
- Reset: assert reset mid-cycle with ld_req=1 -> ld_gnt=0, mem_we=0, ld_rvalid=0, ld_rdata=0 immediately.
- Idle core, loader writes 0xDEADBEEF to 0x40 and then reads 0x40 -> ld_gnt=1 both cycles; ld_rvalid=1 with ld_rdata=0xDEADBEEF one cycle after the read grant.
- Core requests continuously, loader req from cycle 0, MAX_WAIT=4 -> ld_gnt=0 in cycles 0-3, ld_gnt=1 and cpu_stall=1 in cycle 4, wait_cnt=0 in cycle 5.
- Core store 0x11 to 0x80 stalled by a loader write of 0x22 to 0x80 -> memory holds 0x22 after the loader grant, then 0x11 after the core's retried store.
- MAX_WAIT=0, both requesting for 3 cycles -> ld_gnt=1 and cpu_stall=1 every cycle.
- With DMEM_ARB_STATS_EN defined, the previous scenario -> stall_count=3 and grant_count=3. Without the macro, the ports are absent and the same build compiles.
